// File: rtl/bcd_display_decoder.sv
// Sequential binary-to-BCD decoder (double dabble) for the 7-seg path.
// Produces packed BCD digits, sign flag and leading-zero blank mask.
module bcd_display_decoder #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [WIDTH-1:0]      Din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   Dout_bcd,
  output logic                  neg,
  output logic [DIGITS-1:0]     blank,
  output logic [3:0]            Dis_1,
  output logic [3:0]            Dis_2
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] mag_q;
  logic [BW-1:0]    scr_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic [BW-1:0]    bcd_q;
  logic             neg_q;
  logic [DIGITS-1:0] blank_q;
  logic             done_q;

  logic             neg_in;
  logic [WIDTH-1:0] mag_in;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    step_bcd;
  logic [WIDTH-1:0] step_mag;
  logic [DIGITS-1:0] blank_d;
  logic             last;
  logic             zero_run;

  // Negative inputs are converted as their magnitude.
  assign neg_in = (SIGNED != 0) && Din[WIDTH-1];
  assign mag_in = neg_in ? (~Din + WIDTH'(1)) : Din;
  assign last   = (state_q == CONV) && (cnt_q == CW'(WIDTH - 1));

  // One double-dabble step: add 3 to nibbles >= 5, then shift left.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    step_bcd = {adj[BW-2:0], mag_q[WIDTH-1]};
    step_mag = {mag_q[WIDTH-2:0], 1'b0};
  end

  // Leading-zero mask from the final digits; ones digit always shown.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (step_bcd[4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept start in IDLE, return after the last shift.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CONV;
      CONV: if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath and output registers; outputs load only on completion.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      blank_q <= BLANK_RST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE && start) begin
        mag_q  <= mag_in;
        sign_q <= neg_in;
        scr_q  <= '0;
        cnt_q  <= '0;
      end else if (state_q == CONV) begin
        mag_q <= step_mag;
        scr_q <= step_bcd;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          bcd_q   <= step_bcd;
          neg_q   <= sign_q;
          blank_q <= blank_d;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state_q == CONV);
  assign done     = done_q;
  assign Dout_bcd = bcd_q;
  assign neg      = neg_q;
  assign blank    = blank_q;
  assign Dis_1    = bcd_q[3:0];
  assign Dis_2    = bcd_q[7:4];

endmodule

// File: tb/tb_bcd_display_decoder.sv
// Bench for bcd_display_decoder: unsigned and signed instances,
// expected results queued at drive time and checked on done.
module tb_bcd_display_decoder;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    logic [4:0]  blank;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_u = 1'b0;
  logic        start_s = 1'b0;
  logic [15:0] din_u = '0;
  logic [15:0] din_s = '0;

  logic        busy_u, done_u, neg_u;
  logic [19:0] bcd_u;
  logic [4:0]  blank_u;
  logic [3:0]  d1_u, d2_u;
  logic        busy_s, done_s, neg_s;
  logic [19:0] bcd_s;
  logic [4:0]  blank_s;
  logic [3:0]  d1_s, d2_s;

  exp_t q_u[$];
  exp_t q_s[$];
  int   total = 0;
  int   bad = 0;
  int   run_u = 0;
  int   run_s = 0;
  int   ndone_u = 0;
  int   ndone_s = 0;
  int   npush_u = 0;
  int   npush_s = 0;

  always #5 clk = ~clk;

  bcd_display_decoder #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut (
    .CLK(clk), .RST_N(rst_n), .start(start_u), .Din(din_u),
    .busy(busy_u), .done(done_u), .Dout_bcd(bcd_u), .neg(neg_u),
    .blank(blank_u), .Dis_1(d1_u), .Dis_2(d2_u)
  );

  bcd_display_decoder #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) s_dut (
    .CLK(clk), .RST_N(rst_n), .start(start_s), .Din(din_s),
    .busy(busy_s), .done(done_s), .Dout_bcd(bcd_s), .neg(neg_s),
    .blank(blank_s), .Dis_1(d1_s), .Dis_2(d2_s)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [15:0] v, input bit sgn);
    exp_t e;
    int   mag;
    logic z;
    e.neg = sgn && v[15];
    mag = e.neg ? (65536 - int'(v)) : int'(v);
    e.bcd = '0;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    e.blank = '0;
    z = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      z = z & (e.bcd[4*i +: 4] == 4'd0);
      e.blank[i] = z;
    end
    return e;
  endfunction

  task automatic go_u(input logic [15:0] v);
    start_u = 1'b1;
    din_u = v;
    q_u.push_back(model(v, 1'b0));
    npush_u++;
    @(negedge clk);
    start_u = 1'b0;
    din_u = 16'hA5A5;
  endtask

  task automatic go_s(input logic [15:0] v);
    start_s = 1'b1;
    din_s = v;
    q_s.push_back(model(v, 1'b1));
    npush_s++;
    @(negedge clk);
    start_s = 1'b0;
    din_s = 16'h5A5A;
  endtask

  task automatic wait_u();
    for (int i = 0; i < 60 && q_u.size() != 0; i++) @(negedge clk);
    chk("tmo_u", q_u.size(), 0);
  endtask

  task automatic wait_s();
    for (int i = 0; i < 60 && q_s.size() != 0; i++) @(negedge clk);
    chk("tmo_s", q_s.size(), 0);
  endtask

  task automatic chk_rst();
    chk("rst_busy", busy_u, 0);
    chk("rst_done", done_u, 0);
    chk("rst_bcd", bcd_u, 0);
    chk("rst_neg", neg_u, 0);
    chk("rst_blank", blank_u, 5'b11110);
    chk("rst_dis", {d2_u, d1_u}, 0);
    chk("rst_s_neg", neg_s, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy_u) run_u++;
    else if (!done_u) run_u = 0;
    if (done_u) begin
      ndone_u++;
      chk("lat_u", run_u, 16);
      chk("busy_at_done_u", busy_u, 0);
      run_u = 0;
      chk("exp_avail_u", q_u.size() != 0, 1);
      if (q_u.size() != 0) begin
        e = q_u.pop_front();
        chk("bcd_u", bcd_u, e.bcd);
        chk("neg_u", neg_u, e.neg);
        chk("blank_u", blank_u, e.blank);
        chk("dis1_u", d1_u, e.bcd[3:0]);
        chk("dis2_u", d2_u, e.bcd[7:4]);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy_s) run_s++;
    else if (!done_s) run_s = 0;
    if (done_s) begin
      ndone_s++;
      chk("lat_s", run_s, 16);
      run_s = 0;
      chk("exp_avail_s", q_s.size() != 0, 1);
      if (q_s.size() != 0) begin
        e = q_s.pop_front();
        chk("bcd_s", bcd_s, e.bcd);
        chk("neg_s", neg_s, e.neg);
        chk("blank_s", blank_s, e.blank);
        chk("dis1_s", d1_s, e.bcd[3:0]);
      end
    end
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk_rst();
    rst_n = 1'b1;
    @(negedge clk);

    go_u(16'd1234);  wait_u();
    go_u(16'd65535); wait_u();
    go_u(16'd0);     wait_u();

    go_s(16'hFFFF);  wait_s();
    go_s(16'h8000);  wait_s();
    go_s(16'h7FFF);  wait_s();
    go_s(16'hFE0C);  wait_s();
    go_s(16'd0);     wait_s();

    go_u(16'd42);
    repeat (2) @(negedge clk);
    start_u = 1'b1;
    din_u = 16'd9999;
    repeat (2) @(negedge clk);
    start_u = 1'b0;
    repeat (6) @(negedge clk);
    start_u = 1'b1;
    din_u = 16'd9999;
    q_u.push_back(model(16'd9999, 1'b0));
    npush_u++;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done_u;
    end
    chk("b2b_done_seen", seen, 1);
    @(negedge clk);
    chk("b2b_busy", busy_u, 1);
    start_u = 1'b0;
    din_u = 16'd7;
    wait_u();

    start_u = 1'b1;
    din_u = 16'd500;
    @(negedge clk);
    start_u = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_rst();
    repeat (20) @(negedge clk);
    chk("abort_no_done", ndone_u, npush_u);
    go_u(16'd500);
    wait_u();
    go_u(16'd10009);
    wait_u();

    repeat (3) @(negedge clk);
    chk("pend_u", q_u.size(), 0);
    chk("pend_s", q_s.size(), 0);
    chk("ndone_u", ndone_u, npush_u);
    chk("ndone_s", ndone_s, npush_s);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
